// File: rtl/fifo_frame_reader_if.sv
// rtl/fifo_frame_reader_if.sv - FIFO pop port and payload stream bundle for fifo_frame_reader
interface fifo_frame_reader_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - pops a byte FIFO, parses length-prefixed XOR-checked frames, forwards payload
module fifo_frame_reader #(
  parameter int MAX_LEN = 255,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 enable,
  fifo_frame_reader_if.master  bus,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     ok_count,
  output logic [CNT_W-1:0]     err_count
);
  typedef enum logic [1:0] {HDR, PAYLOAD, CHECK, DISCARD} state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t     state;
  logic [7:0] skid_mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] skid_count;
  logic       in_flight;
  logic [7:0] rem;
  logic [7:0] csum;

  logic [7:0] head;
  logic       has_head;
  logic       pop;
  logic [1:0] occupancy;

  assign head     = skid_mem[rd_ptr];
  assign has_head = skid_count != 2'd0;
  assign pop      = has_head && (state != PAYLOAD || bus.out_ready);

  // Occupancy after this edge; counting the head consumed this cycle as freed keeps 1 byte/clk.
  assign occupancy      = skid_count - {1'b0, pop} + {1'b0, in_flight};
  assign bus.fifo_rd_en = srst_n && enable && !bus.fifo_empty && (occupancy < 2'd2);

  assign bus.out_valid = (state == PAYLOAD) && has_head;
  assign bus.out_data  = bus.out_valid ? head : 8'h00;
  assign bus.out_last  = bus.out_valid && (rem == 8'd1);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state       <= HDR;
      skid_mem[0] <= 8'h00;
      skid_mem[1] <= 8'h00;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      skid_count  <= 2'd0;
      in_flight   <= 1'b0;
      rem         <= 8'h00;
      csum        <= 8'h00;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      in_flight  <= bus.fifo_rd_en;
      skid_count <= occupancy;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (in_flight) begin
        skid_mem[wr_ptr] <= bus.fifo_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        unique case (state)
          HDR: begin
            csum <= head;
            rem  <= head;
            if (head == 8'd0) begin
              frame_err <= 1'b1;
            end else if ({1'b0, head} > MAX_LEN_W) begin
              frame_err <= 1'b1;
              state     <= DISCARD;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            csum <= csum ^ head;
            rem  <= rem - 8'd1;
            if (rem == 8'd1) state <= CHECK;
          end
          CHECK: begin
            frame_ok  <= (head == csum);
            frame_err <= (head != csum);
            state     <= HDR;
          end
          DISCARD: begin
            // rem counts the remaining payload; the checksum byte is the extra one at rem == 0.
            if (rem == 8'd0) state <= HDR;
            else             rem   <= rem - 8'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      ok_count  <= '0;
      err_count <= '0;
    end else begin
      if (frame_ok && ok_count != {CNT_W{1'b1}})   ok_count  <= ok_count + CNT_W'(1);
      if (frame_err && err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
    end
  end
endmodule
